// File: rtl/divider_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Wide enough to hold WIDTH-1 with a spare bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division stage: shift in one dividend bit, trial subtract.
module divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {part_rem, in_bit};
  // Top bit of the WIDTH+1 result is the borrow; part_rem < divisor keeps it exact.
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider, one quotient bit per clock.
// Optional DIVIDER_DBZ_EN: dbz output and single-cycle divide-by-zero shortcut.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divider,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef DIVIDER_DBZ_EN
  output logic             dbz,
`endif
  output logic             ready
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   rem_nxt;
  logic               q_bit;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               done;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .part_rem (rem_q),
    .in_bit   (shift_q[WIDTH-1]),
    .divisor  (div_q),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign ready = (state == IDLE);

`ifdef DIVIDER_DBZ_EN
  logic dbz_hit;
  assign dbz_hit = (state == BUSY) && (cnt == '0) && (div_q == '0);
  assign done    = last || dbz_hit;
`else
  assign done    = last;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: if (done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DBZ_EN
      dbz       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            shift_q <= dividend;
            div_q   <= divider;
            rem_q   <= '0;
            cnt     <= '0;
          end
        end
        BUSY: begin
`ifdef DIVIDER_DBZ_EN
          if (dbz_hit) begin
            // Shift register still holds the untouched dividend on the first step.
            quotient  <= '1;
            remainder <= shift_q;
            dbz       <= 1'b1;
          end else begin
`endif
            shift_q <= {shift_q[WIDTH-2:0], q_bit};
            rem_q   <= rem_nxt;
            cnt     <= cnt + 1'b1;
            if (last) begin
              quotient  <= {shift_q[WIDTH-2:0], q_bit};
              remainder <= rem_nxt;
`ifdef DIVIDER_DBZ_EN
              dbz       <= 1'b0;
`endif
            end
`ifdef DIVIDER_DBZ_EN
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner sequences, random ops.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] dividend, divider;
  logic         start;
  logic [W-1:0] quotient, remainder;
  logic         ready;
`ifdef DIVIDER_DBZ_EN
  logic         dbz;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] prev_q, prev_r;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .dividend  (dividend),
    .divider   (divider),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef DIVIDER_DBZ_EN
    .dbz       (dbz),
`endif
    .ready     (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    if (dv == 0) begin
      q = {W{1'b1}};
      r = dd;
    end else begin
      q = dd / dv;
      r = dd % dv;
    end
  endfunction

  function automatic int exp_latency(input logic [W-1:0] dv);
`ifdef DIVIDER_DBZ_EN
    if (dv == 0) return 1;
`endif
    return W;
  endfunction

  // glitch_at > 0 re-pulses start with different operands on that busy cycle.
  task automatic do_op(input string nm, input logic [W-1:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input int glitch_at);
    int lat;
    @(negedge clk);
    dividend = dd;
    divider  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_ready"}, {31'd0, ready}, 32'd0);
    check({nm, "_hold_q"}, {16'd0, quotient}, {16'd0, prev_q});
    lat = 0;
    while (!ready && lat < 100) begin
      lat++;
      if (lat == glitch_at) begin
        dividend = ~dd;
        divider  = 16'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({nm, "_latency"}, lat, exp_latency(dv));
    check({nm, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
    check({nm, "_remainder"}, {16'd0, remainder}, {16'd0, er});
`ifdef DIVIDER_DBZ_EN
    check({nm, "_dbz"}, {31'd0, dbz}, {31'd0, (dv == 0)});
`endif
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    logic [W-1:0] dd, dv, eq, er;
    int first_hi, last_hi, n_hi, wait_cnt;

    vecs[0] = '{16'd50,    16'd23,    16'd2,     16'd4};
    vecs[1] = '{16'd65535, 16'd1,     16'd65535, 16'd0};
    vecs[2] = '{16'd7,     16'd9,     16'd0,     16'd7};
    vecs[3] = '{16'd1234,  16'd0,     16'd65535, 16'd1234};
    vecs[4] = '{16'd100,   16'd10,    16'd10,    16'd0};
    vecs[5] = '{16'd1000,  16'd7,     16'd142,   16'd6};
    vecs[6] = '{16'd65535, 16'd65535, 16'd1,     16'd0};
    vecs[7] = '{16'd0,     16'd5,     16'd0,     16'd0};
    vecs[8] = '{16'd32768, 16'd3,     16'd10922, 16'd2};
    vecs[9] = '{16'd65535, 16'd2,     16'd32767, 16'd1};

    rst = 1'b0;
    start = 1'b0;
    dividend = '0;
    divider = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_quotient", {16'd0, quotient}, 32'd0);
    check("reset_remainder", {16'd0, remainder}, 32'd0);
`ifdef DIVIDER_DBZ_EN
    check("reset_dbz", {31'd0, dbz}, 32'd0);
`endif
    prev_q = '0;
    prev_r = '0;
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, 0);

    // Start re-pulsed mid-operation must be ignored.
    do_op("ignore_start", 16'd50, 16'd23, 16'd2, 16'd4, 5);

    // Async reset mid-operation aborts to reset values.
    @(negedge clk);
    dividend = 16'd1000;
    divider  = 16'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_quotient", {16'd0, quotient}, 32'd0);
    check("abort_remainder", {16'd0, remainder}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    prev_q = '0;
    prev_r = '0;
    do_op("after_abort", 16'd1000, 16'd7, 16'd142, 16'd6, 0);

    // Start held high: one idle cycle between back-to-back operations.
    @(negedge clk);
    dividend = 16'd100;
    divider  = 16'd10;
    start    = 1'b1;
    first_hi = -1;
    last_hi  = -1;
    n_hi     = 0;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      if (ready) begin
        n_hi++;
        if (first_hi < 0) first_hi = k;
        else check("held_period", k - last_hi, 17);
        last_hi = k;
        check("held_quotient", {16'd0, quotient}, 32'd10);
        check("held_remainder", {16'd0, remainder}, 32'd0);
      end
    end
    check("held_first", first_hi, 17);
    check("held_count", n_hi, 3);
    start = 1'b0;
    wait_cnt = 0;
    while (!ready && wait_cnt < 100) begin
      wait_cnt++;
      @(negedge clk);
    end
    check("held_drain", {31'd0, ready}, 32'd1);
    prev_q = 16'd10;
    prev_r = 16'd0;

    for (int i = 0; i < 40; i++) begin
      dd = W'($urandom);
      case ($urandom_range(0, 3))
        0: dv = W'($urandom_range(1, 15));
        1: dv = W'($urandom_range(0, 255));
        default: dv = W'($urandom);
      endcase
      model(dd, dv, eq, er);
      do_op($sformatf("rand%0d", i), dd, dv, eq, er, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider, one quotient bit per clock (radix-2 restoring algorithm).
- Accepts dividend/divisor on a start pulse and produces quotient and remainder.
- Raises ready when the result is valid.
- Shared arithmetic helper for datapath blocks (e.g. modular reduction in the Diffie-Hellman core) that tolerate WIDTH-cycle latency.

Parameters:
WIDTH  16  operand and result width in bits (>=2)

Ports:
clk        in   1      rising-edge clock
rst        in   1      asynchronous reset, active-low (0 = reset)
dividend   in   WIDTH  unsigned dividend, sampled on accepted start
divider    in   WIDTH  unsigned divisor, sampled on accepted start
start      in   1      request; level-sampled on clk while idle
quotient   out  WIDTH  registered quotient of last completed operation
remainder  out  WIDTH  registered remainder of last completed operation
ready      out  1      high = idle and quotient/remainder valid

Behaviour:
- Reset (rst=0, async, no clk needed):
  - state=IDLE, ready=1, quotient=0, remainder=0.
  - Internal shift/partial-remainder registers cleared.
- States: IDLE, BUSY.
- IDLE:
  - ready=1.
  - On the clk edge where start=1: latch dividend into the shift register and divisor into the divisor register, clear the partial remainder, counter=0, go BUSY, ready drops to 0.
  - start=0 keeps IDLE.
- BUSY: each edge performs one restoring step:
  - Shift {partial_rem, shift_reg} left 1.
  - Trial = partial_rem_shifted - divisor, computed at WIDTH+1 bits.
  - If non-negative: partial_rem = trial, and the shifted-in quotient LSB = 1. Otherwise partial_rem is kept and LSB = 0.
  - Counter increments.
- Completion:
  - On the WIDTH-th BUSY edge (edge WIDTH after the start edge), quotient/remainder are loaded with the final values, ready=1, and the state returns to IDLE.
  - ready is therefore low for exactly WIDTH cycles.
- quotient/remainder hold their previous values throughout BUSY. They change only at completion or reset.
- start while BUSY is ignored. Operand changes while BUSY have no effect.
- start held high continuously: a new operation is accepted on the first edge after completion, so ready is high for one cycle.
- Divisor 0 (no special logic needed): quotient = all ones (2^WIDTH-1), remainder = dividend, same latency.
- Reset asserted mid-operation: abort immediately to reset values. The operation is not resumed.
- All arithmetic is unsigned. The partial-remainder subtract is WIDTH+1 bits wide to capture the borrow.

Optional Feature:
- Macro DIVIDER_DBZ_EN.
- Defined:
  - Adds output port dbz (1 bit), reset 0.
  - If the latched divisor is 0, the block skips iteration: at the first BUSY edge it loads quotient = all ones, remainder = dividend, sets dbz=1 and ready=1.
  - dbz is updated at every completion (0 for a non-zero divisor) and held otherwise.
- Undefined: no dbz port; divide-by-zero runs the normal WIDTH cycles with the same result values.

Decomposition:
- Package divider_pkg holds:
  - DIV_WIDTH_DEFAULT = 16.
  - The state enum type (IDLE, BUSY).
  - The counter width, computed as clog2(WIDTH)+1.
- Sub-module divider_step: combinational single restoring stage (inputs partial_rem, next dividend bit, divisor; outputs new partial_rem, quotient bit). Instantiated once in the BUSY datapath.

Test Plan:
- Reset, then dividend=50, divider=23, one-cycle start -> ready low 16 cycles, then quotient=2, remainder=4, ready=1.
- dividend=65535, divider=1 -> quotient=65535, remainder=0. dividend=7, divider=9 -> quotient=0, remainder=7.
- dividend=1234, divider=0 -> quotient=65535, remainder=1234 after 16 cycles. With DIVIDER_DBZ_EN: after 1 cycle, dbz=1.
- Start, then pulse start with new operands at BUSY cycle 5 -> ignored, result for the original operands, completion still at cycle 16.
- Start 1000/7, assert rst=0 at BUSY cycle 8 -> immediately ready=1, quotient=0, remainder=0. A subsequent start of 1000/7 yields 142 r 6.
- start held high with fixed operands 100/10 -> ready pulses high for one cycle every 17 cycles, quotient=10, remainder=0 each time.
